// File: rtl/move_pulse_gen.sv
// Turns four raw direction buttons into clean one-cycle step pulses for the
// cursor-position stage: synchronise, debounce, cancel opposites, auto-repeat.
module move_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int ACTIVE_LOW      = 1,
    parameter int CNT_W           = 25
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic btnLeft,
    input  logic btnRight,
    input  logic btnUp,
    input  logic btnDown,
    output logic left,
    output logic right,
    output logic up,
    output logic down,
    output logic anyHeld
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       POL_MASK = (ACTIVE_LOW != 0) ? 4'hF : 4'h0;

    // Channel order everywhere: [0]=left, [1]=right, [2]=up, [3]=down.
    logic [3:0] w_raw;
    logic [3:0] w_deb;
    logic [3:0] w_eff;
    logic [3:0] w_pulse;
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic       r_any_held;

    // After normalisation 1 means pressed, so reset leaves the chain "released".
    assign w_raw = {btnDown, btnUp, btnRight, btnLeft} ^ POL_MASK;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Opposite directions held together cancel each other on that axis.
    assign w_eff = {w_deb[3] & ~w_deb[2],
                    w_deb[2] & ~w_deb[3],
                    w_deb[1] & ~w_deb[0],
                    w_deb[0] & ~w_deb[1]};

    for (genvar g = 0; g < 4; g++) begin : g_chan
        logic             r_deb;
        logic [CNT_W-1:0] r_dc;
        rep_state_t       r_state;
        rep_state_t       w_next;
        logic [CNT_W-1:0] r_rc;
        logic             w_fire;
        logic             w_rc_clr;
        logic             r_pulse;

        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                r_deb <= 1'b0;
                r_dc  <= '0;
            end else if (r_sync2[g] == r_deb) begin
                r_dc  <= '0;
            end else if (r_dc == DB_LAST) begin
                r_deb <= r_sync2[g];
                r_dc  <= '0;
            end else begin
                r_dc  <= r_dc + CNT_ONE;
            end
        end

        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                r_state <= ST_IDLE;
            end else begin
                r_state <= w_next;
            end
        end

        always_comb begin
            w_next = r_state;
            case (r_state)
                ST_IDLE:   if (w_eff[g]) w_next = ST_DELAY;
                ST_DELAY: begin
                    if (!w_eff[g])             w_next = ST_IDLE;
                    else if (r_rc == RD_LAST)  w_next = ST_REPEAT;
                end
                ST_REPEAT: if (!w_eff[g]) w_next = ST_IDLE;
                default:   w_next = ST_IDLE;
            endcase
        end

        // A falling effective press wins over a coinciding repeat pulse.
        always_comb begin
            w_fire   = 1'b0;
            w_rc_clr = 1'b1;
            case (r_state)
                ST_IDLE: w_fire = w_eff[g];
                ST_DELAY: begin
                    w_fire   = w_eff[g] && (r_rc == RD_LAST);
                    w_rc_clr = !w_eff[g] || w_fire;
                end
                ST_REPEAT: begin
                    w_fire   = w_eff[g] && (r_rc == RP_LAST);
                    w_rc_clr = !w_eff[g] || w_fire;
                end
                default: w_fire = 1'b0;
            endcase
        end

        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                r_rc    <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_rc    <= w_rc_clr ? '0 : r_rc + CNT_ONE;
                r_pulse <= w_fire;
            end
        end

        assign w_deb[g]   = r_deb;
        assign w_pulse[g] = r_pulse;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_any_held <= 1'b0;
        end else begin
            r_any_held <= |w_deb;
        end
    end

    assign left    = w_pulse[0];
    assign right   = w_pulse[1];
    assign up      = w_pulse[2];
    assign down    = w_pulse[3];
    assign anyHeld = r_any_held;

endmodule

// File: tb/tb_move_pulse_gen.sv
// Bench for move_pulse_gen: records every cycle, then compares the DUT against
// a trace-level reference model plus hand-derived pulse timings per scenario.
module tb_move_pulse_gen;
  localparam int DB   = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam int MAXN = 4000;

  logic CLOCK_50;
  logic reset;
  logic btnLeft, btnRight, btnUp, btnDown;
  logic left, right, up, down, anyHeld;

  int n_checks = 0;
  int n_fail   = 0;
  int ncyc     = 0;

  // History, indexed by clock edge number.
  logic [3:0] raw_h [MAXN];
  logic       rst_h [MAXN];
  logic [4:0] obs_h [MAXN];
  logic [4:0] exp_h [MAXN];
  logic [3:0] d_h   [MAXN];
  logic [3:0] e_h   [MAXN];

  move_pulse_gen #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .ACTIVE_LOW(0),
    .CNT_W(8)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .btnLeft(btnLeft),
    .btnRight(btnRight),
    .btnUp(btnUp),
    .btnDown(btnDown),
    .left(left),
    .right(right),
    .up(up),
    .down(down),
    .anyHeld(anyHeld)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // One clock edge: log inputs seen at the edge and outputs just after it.
  task automatic step();
    if (ncyc >= MAXN) begin
      $display("FAIL history_overflow: cycles %0d, limit %0d", ncyc, MAXN);
      $fatal(1);
    end
    raw_h[ncyc] = {btnDown, btnUp, btnRight, btnLeft};
    rst_h[ncyc] = reset;
    @(posedge CLOCK_50);
    #1;
    obs_h[ncyc] = {anyHeld, down, up, right, left};
    ncyc++;
  endtask

  // Reference: debounced level per channel from the raw trace, then pulses from
  // runs of effective press (first pulse, +RD, then every RP while the run lasts).
  task automatic run_model();
    logic [3:0] s1, s2, d, nd, pulse;
    logic       any;
    int         dc [4];
    int         run_start [4];
    int         off;
    s1 = '0; s2 = '0; d = '0;
    for (int c = 0; c < 4; c++) begin
      dc[c] = 0;
      run_start[c] = 0;
    end
    for (int n = 0; n < ncyc; n++) begin
      if (rst_h[n]) begin
        s1 = '0; s2 = '0; d = '0;
        for (int c = 0; c < 4; c++) dc[c] = 0;
      end else begin
        nd = d;
        for (int c = 0; c < 4; c++) begin
          if (s2[c] == d[c]) dc[c] = 0;
          else if (dc[c] == DB - 1) begin
            nd[c] = s2[c];
            dc[c] = 0;
          end else dc[c] = dc[c] + 1;
        end
        d  = nd;
        s2 = s1;
        s1 = raw_h[n];
      end
      d_h[n] = d;
      e_h[n] = {d[3] & ~d[2], d[2] & ~d[3], d[1] & ~d[0], d[0] & ~d[1]};
    end
    for (int n = 0; n < ncyc; n++) begin
      pulse = '0;
      any   = 1'b0;
      if (n > 0) begin
        for (int c = 0; c < 4; c++) begin
          if (e_h[n-1][c]) begin
            if (n == 1 || !e_h[n-2][c]) run_start[c] = n - 1;
            off = n - 1 - run_start[c];
            if (off == 0 || off == RD || (off > RD && (off - RD) % RP == 0))
              pulse[c] = 1'b1;
          end
        end
        any = |d_h[n-1];
      end
      if (rst_h[n]) begin
        pulse = '0;
        any   = 1'b0;
      end
      exp_h[n] = {any, pulse};
    end
  endtask

  task automatic test_reset();
    int t0, k;
    t0 = ncyc;
    reset = 1'b1;
    btnLeft = 1'b0; btnRight = 1'b1; btnUp = 1'b0; btnDown = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    k = ncyc;
    repeat (8) step();
    btnRight = 1'b0;
    repeat (12) step();
    for (int n = t0; n < k; n++) begin
      n_checks++;
      if (obs_h[n] !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_outputs edge %0d: got %b want 00000", n, obs_h[n]);
      end
    end
    for (int n = k; n < ncyc; n++) begin
      logic want;
      want = (n == k + 6);
      n_checks++;
      if (obs_h[n][1] !== want) begin
        n_fail++;
        $display("FAIL reset_first_right edge %0d: got %b want %b", n, obs_h[n][1], want);
      end
    end
    run_model();
    for (int n = t0; n < ncyc; n++) begin
      n_checks++;
      if (obs_h[n] !== exp_h[n]) begin
        n_fail++;
        $display("FAIL reset_model edge %0d: got %b want %b", n, obs_h[n], exp_h[n]);
      end
    end
  endtask

  task automatic test_clean_press();
    int t0, k;
    t0 = ncyc;
    btnRight = 1'b1;
    k = ncyc;
    repeat (24) step();
    btnRight = 1'b0;
    repeat (14) step();
    for (int n = k; n < ncyc; n++) begin
      logic want;
      want = ((n - k) inside {6, 16, 19, 22, 25, 28});
      n_checks++;
      if (obs_h[n][1] !== want || obs_h[n][0] !== 1'b0 || obs_h[n][3:2] !== 2'b00) begin
        n_fail++;
        $display("FAIL clean_press edge %0d: got %b want right=%b others 0", n, obs_h[n][3:0], want);
      end
    end
    run_model();
    for (int n = t0; n < ncyc; n++) begin
      n_checks++;
      if (obs_h[n] !== exp_h[n]) begin
        n_fail++;
        $display("FAIL clean_model edge %0d: got %b want %b", n, obs_h[n], exp_h[n]);
      end
    end
  endtask

  task automatic test_bounce();
    int t0, h;
    t0 = ncyc;
    btnUp = 1'b1; step();
    btnUp = 1'b0; step();
    btnUp = 1'b1; step();
    btnUp = 1'b0; step();
    btnUp = 1'b1;
    h = ncyc;
    repeat (8) step();
    btnUp = 1'b0;
    repeat (12) step();
    for (int n = t0; n < ncyc; n++) begin
      logic want;
      want = (n == h + 6);
      n_checks++;
      if (obs_h[n][2] !== want) begin
        n_fail++;
        $display("FAIL bounce_up edge %0d: got %b want %b", n, obs_h[n][2], want);
      end
    end
    run_model();
    for (int n = t0; n < ncyc; n++) begin
      n_checks++;
      if (obs_h[n] !== exp_h[n]) begin
        n_fail++;
        $display("FAIL bounce_model edge %0d: got %b want %b", n, obs_h[n], exp_h[n]);
      end
    end
  endtask

  task automatic test_glitch();
    int t0;
    t0 = ncyc;
    btnDown = 1'b1;
    repeat (3) step();
    btnDown = 1'b0;
    repeat (12) step();
    for (int n = t0; n < ncyc; n++) begin
      n_checks++;
      if (obs_h[n][3] !== 1'b0 || obs_h[n][4] !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch edge %0d: got down=%b anyHeld=%b want 0 0", n, obs_h[n][3], obs_h[n][4]);
      end
    end
    run_model();
    for (int n = t0; n < ncyc; n++) begin
      n_checks++;
      if (obs_h[n] !== exp_h[n]) begin
        n_fail++;
        $display("FAIL glitch_model edge %0d: got %b want %b", n, obs_h[n], exp_h[n]);
      end
    end
  endtask

  task automatic test_conflict();
    int t0, kl, rel;
    t0 = ncyc;
    btnLeft = 1'b1;
    kl = ncyc;
    repeat (8) step();
    btnRight = 1'b1;
    repeat (10) step();
    btnRight = 1'b0;
    rel = ncyc;
    repeat (20) step();
    btnLeft = 1'b0;
    repeat (12) step();
    for (int n = t0; n < ncyc; n++) begin
      logic want;
      want = (n == kl + 6) || ((n - rel) inside {6, 16, 19, 22, 25});
      n_checks++;
      if (obs_h[n][0] !== want || obs_h[n][1] !== 1'b0) begin
        n_fail++;
        $display("FAIL conflict edge %0d: got left=%b right=%b want %b 0", n, obs_h[n][0], obs_h[n][1], want);
      end
    end
    run_model();
    for (int n = t0; n < ncyc; n++) begin
      n_checks++;
      if (obs_h[n] !== exp_h[n]) begin
        n_fail++;
        $display("FAIL conflict_model edge %0d: got %b want %b", n, obs_h[n], exp_h[n]);
      end
    end
  endtask

  task automatic test_diagonal();
    int t0, k;
    t0 = ncyc;
    btnUp = 1'b1;
    btnRight = 1'b1;
    k = ncyc;
    repeat (20) step();
    btnUp = 1'b0;
    btnRight = 1'b0;
    repeat (12) step();
    for (int n = t0; n < ncyc; n++) begin
      logic want;
      want = ((n - k) inside {6, 16, 19, 22, 25});
      n_checks++;
      if (obs_h[n][2] !== want || obs_h[n][1] !== want) begin
        n_fail++;
        $display("FAIL diagonal edge %0d: got up=%b right=%b want %b", n, obs_h[n][2], obs_h[n][1], want);
      end
    end
    run_model();
    for (int n = t0; n < ncyc; n++) begin
      n_checks++;
      if (obs_h[n] !== exp_h[n]) begin
        n_fail++;
        $display("FAIL diagonal_model edge %0d: got %b want %b", n, obs_h[n], exp_h[n]);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    int t0, k, k2;
    t0 = ncyc;
    btnUp = 1'b1;
    k = ncyc;
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    k2 = ncyc;
    repeat (9) step();
    btnUp = 1'b0;
    repeat (12) step();
    for (int n = t0; n < ncyc; n++) begin
      logic want;
      want = (n == k + 6) || (n == k2 + 6);
      n_checks++;
      if (obs_h[n][2] !== want) begin
        n_fail++;
        $display("FAIL reset_mid_press edge %0d: got %b want %b", n, obs_h[n][2], want);
      end
    end
    run_model();
    for (int n = t0; n < ncyc; n++) begin
      n_checks++;
      if (obs_h[n] !== exp_h[n]) begin
        n_fail++;
        $display("FAIL reset_mid_model edge %0d: got %b want %b", n, obs_h[n], exp_h[n]);
      end
    end
  endtask

  task automatic test_random();
    int t0, len;
    t0 = ncyc;
    repeat (60) begin
      {btnDown, btnUp, btnRight, btnLeft} = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 19) == 0);
      len = reset ? 1 : $urandom_range(1, 24);
      repeat (len) step();
      reset = 1'b0;
    end
    {btnDown, btnUp, btnRight, btnLeft} = 4'b0;
    repeat (15) step();
    run_model();
    for (int n = t0; n < ncyc; n++) begin
      n_checks++;
      if (obs_h[n] !== exp_h[n]) begin
        n_fail++;
        $display("FAIL random_model edge %0d: got %b want %b", n, obs_h[n], exp_h[n]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_conflict();
    test_diagonal();
    test_reset_mid_press();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
